// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// The package also holds one elaboration-time helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam int LOSS_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Sideband bundle between the reset sequencer and the PLL wrapper / system reset fabric.
// The master side is the sequencer. The slave side is the environment.
interface pll_reset_sequencer_if #(
    parameter int MAX_RETRIES = 3
);
    import pll_seq_pkg::*;

    localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic                  pll_locked;
    logic                  relock_req;
    logic                  pll_rst;
    logic                  sys_rst;
    logic                  ready;
    logic                  lock_fail;
    logic [RC_W-1:0]       retry_count;
    logic [LOSS_CNT_W-1:0] lock_loss_cnt;

    modport master (
        input  pll_locked, relock_req,
        output pll_rst, sys_rst, ready, lock_fail, retry_count, lock_loss_cnt
    );

    modport slave (
        output pll_locked, relock_req,
        input  pll_rst, sys_rst, ready, lock_fail, retry_count, lock_loss_cnt
    );

endinterface

// File: rtl/sync_bit.sv
// Generic multi-flop synchroniser for a single asynchronous level signal.
// It clears to 0 on rst.
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the board PLL reset from the reference clock and releases sys_rst only after a stable lock.
// It retries on lock timeout and restarts on relock_req or on lock loss.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2
) (
    input logic                   refclk,
    input logic                   rst,
    pll_reset_sequencer_if.master bus
);

    localparam int CNT_MAX = max3(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RC_W    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RC_MAX       = RC_W'(MAX_RETRIES);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RC_W-1:0]       retry_q, retry_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  pll_rst_q, sys_rst_q, ready_q, lock_fail_q;
    logic                  locked_s;

    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (locked_s)
    );

    // relock_req outranks lock events, which outrank counter expiry
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (bus.relock_req && (state_q != HOLD)) begin
            state_d = HOLD;
            retry_d = '0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABILIZE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q == RC_MAX) begin
                            state_d = FAIL;
                        end else begin
                            state_d = HOLD;
                            retry_d = retry_q + 1'b1;
                        end
                    end
                end
                STABILIZE: begin
                    if (!locked_s) state_d = WAIT_LOCK;
                    else if (cnt_q == STABLE_LAST) state_d = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d = HOLD;
                        retry_d = '0;
                        loss_d  = (loss_q == '1) ? loss_q : loss_q + 1'b1;
                    end
                end
                FAIL: state_d = FAIL;
                default: state_d = HOLD;
            endcase
        end
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == HOLD) || (state_d == FAIL);
            sys_rst_q   <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
            lock_fail_q <= (state_d == FAIL);
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_rst       = sys_rst_q;
    assign bus.ready         = ready_q;
    assign bus.lock_fail     = lock_fail_q;
    assign bus.retry_count   = retry_q;
    assign bus.lock_loss_cnt = loss_q;

endmodule
